// File: rtl/aq_axis_pkg.sv
// Shared types for the AXI-Stream packet arbiter: FSM encoding and TID width helper.
package aq_axis_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StXfer = 1'b1
  } arb_state_e;

  // Width of a source index; never narrower than one bit.
  function automatic int unsigned tid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aq_rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr_i wins.
module aq_rr_arbiter
  import aq_axis_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = tid_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = IDX_W'((32'(ptr_i) + k) % NUM_SRC);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aq_axis_arb.sv
// Packet-level round-robin AXI-Stream arbiter feeding a single FIFO write port.
// Optional M_AXIS_TID output when AQ_AXIS_ARB_TID_EN is defined.
module aq_axis_arb
  import aq_axis_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned FIFO_WIDTH = 64
) (
  input  logic                             ACLK,
  input  logic                             RST,
  input  logic [NUM_SRC-1:0]               S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]               S_AXIS_TREADY,
  input  logic [NUM_SRC-1:0]               S_AXIS_TLAST,
  input  logic [NUM_SRC*FIFO_WIDTH-1:0]    S_AXIS_TDATA,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic                             M_AXIS_TLAST,
  output logic [FIFO_WIDTH-1:0]            M_AXIS_TDATA,
  input  logic                             FIFO_WR_ALM_FULL,
  output logic [NUM_SRC-1:0]               GRANT,
  output logic [31:0]                      PKT_COUNT
`ifdef AQ_AXIS_ARB_TID_EN
  ,
  output logic [tid_width(NUM_SRC)-1:0]    M_AXIS_TID
`endif
);

  localparam int unsigned IdxW = tid_width(NUM_SRC);

  arb_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [31:0]         pkt_count_q, pkt_count_d;
  logic [IdxW-1:0]     ptr;
  logic [NUM_SRC-1:0]  arb_gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                xfer_act;
  logic                beat;

  assign ptr = (last_q == IdxW'(NUM_SRC - 1)) ? '0 : last_q + IdxW'(1);

  aq_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IdxW)
  ) u_rr (
    .req_i (S_AXIS_TVALID),
    .ptr_i (ptr),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (arb_gnt[k]) gnt_idx = IdxW'(k);
    end
  end

  // Datapath is forced quiet while reset is asserted, even mid-packet.
  assign xfer_act      = (state_q == StXfer) && !RST;
  assign M_AXIS_TVALID = xfer_act && S_AXIS_TVALID[idx_q];
  assign M_AXIS_TLAST  = xfer_act && S_AXIS_TLAST[idx_q];
  assign M_AXIS_TDATA  = S_AXIS_TDATA[32'(idx_q)*FIFO_WIDTH +: FIFO_WIDTH];
  assign S_AXIS_TREADY = xfer_act ? (grant_q & {NUM_SRC{M_AXIS_TREADY}}) : '0;
  assign beat          = M_AXIS_TVALID && M_AXIS_TREADY;
  assign GRANT         = grant_q;
  assign PKT_COUNT     = pkt_count_q;

`ifdef AQ_AXIS_ARB_TID_EN
  assign M_AXIS_TID = xfer_act ? idx_q : '0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    last_d      = last_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      StIdle: begin
        if ((|S_AXIS_TVALID) && !FIFO_WR_ALM_FULL) begin
          state_d = StXfer;
          grant_d = arb_gnt;
          idx_d   = gnt_idx;
        end
      end
      StXfer: begin
        if (beat && M_AXIS_TLAST) begin
          state_d     = StIdle;
          grant_d     = '0;
          last_d      = idx_q;
          pkt_count_d = pkt_count_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // last_q resets to the top index so the first search starts at source 0.
  always_ff @(posedge ACLK) begin
    if (RST) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      idx_q       <= '0;
      last_q      <= IdxW'(NUM_SRC - 1);
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_aq_axis_arb.sv
// Directed self-checking bench for aq_axis_arb (NUM_SRC=4, FIFO_WIDTH=64).
module tb_aq_axis_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [3:0]   s_tlast;
  logic [255:0] s_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [63:0]  m_tdata;
  logic         alm_full;
  logic [3:0]   grant;
  logic [31:0]  pkt_count;
`ifdef AQ_AXIS_ARB_TID_EN
  logic [1:0]   m_tid;
`endif

  aq_axis_arb #(
    .NUM_SRC    (4),
    .FIFO_WIDTH (64)
  ) dut (
    .ACLK             (clk),
    .RST              (rst),
    .S_AXIS_TVALID    (s_tvalid),
    .S_AXIS_TREADY    (s_tready),
    .S_AXIS_TLAST     (s_tlast),
    .S_AXIS_TDATA     (s_tdata),
    .M_AXIS_TVALID    (m_tvalid),
    .M_AXIS_TREADY    (m_tready),
    .M_AXIS_TLAST     (m_tlast),
    .M_AXIS_TDATA     (m_tdata),
    .FIFO_WR_ALM_FULL (alm_full),
    .GRANT            (grant),
    .PKT_COUNT        (pkt_count)
`ifdef AQ_AXIS_ARB_TID_EN
    ,
    .M_AXIS_TID       (m_tid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          blen [4];
  int          bleft[4];
  int          bbeat[4];
  int          bpkt [4];
  logic        toggle_rdy;
  logic [63:0] cap_q[$];
  logic [3:0]  gnt_log[$];
  logic [3:0]  gnt_prev;
  int          gap_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(input int s, input int p, input int b);
    return {32'(s), 16'(p), 16'(b)};
  endfunction

  function automatic logic [3:0] get_gnt(input int k);
    return (k < gnt_log.size()) ? gnt_log[k] : 4'h0;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i]          = (bleft[i] > 0);
      s_tlast[i]           = (bbeat[i] == blen[i] - 1);
      s_tdata[i*64 +: 64]  = mkdata(i, bpkt[i], bbeat[i]);
    end
  endtask

  // Called at a negedge: log outputs, cross the posedge, advance the source model.
  task automatic tick();
    logic [3:0] xfer;
    xfer = s_tvalid & s_tready;
    if (m_tvalid && m_tready) cap_q.push_back(m_tdata);
    if (grant != 4'h0 && gnt_prev == 4'h0) gnt_log.push_back(grant);
    if (grant == 4'h0 && s_tvalid != 4'h0) gap_cnt++;
    gnt_prev = grant;
`ifdef AQ_AXIS_ARB_TID_EN
    if (grant == 4'b1000) check("tid_src3", 64'(m_tid), 64'd3);
    else if (grant == 4'h0) check("tid_idle", 64'(m_tid), 64'd0);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (xfer[i]) begin
        bbeat[i]++;
        if (bbeat[i] == blen[i]) begin
          bbeat[i] = 0;
          bpkt[i]++;
          bleft[i]--;
        end
      end
    end
    if (toggle_rdy) m_tready = ~m_tready;
    drive_srcs();
    @(negedge clk);
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pkt_count != 32'(target) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(pkt_count), 64'(target));
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < 4; i++) begin
      blen[i]  = 1;
      bleft[i] = 0;
      bbeat[i] = 0;
      bpkt[i]  = 0;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    m_tready   = 1'b1;
    alm_full   = 1'b0;
    toggle_rdy = 1'b0;
    clear_srcs();
    drive_srcs();
    tick();
    tick();
    rst = 1'b0;
    cap_q.delete();
    gnt_log.delete();
    gnt_prev = 4'h0;
    gap_cnt  = 0;
  endtask

  initial begin
    rst        = 1'b1;
    m_tready   = 1'b1;
    alm_full   = 1'b0;
    toggle_rdy = 1'b0;
    s_tvalid   = '0;
    s_tlast    = '0;
    s_tdata    = '0;
    gnt_prev   = 4'h0;
    gap_cnt    = 0;
    clear_srcs();
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_pkt_count", 64'(pkt_count), 64'h0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'h0);
    check("rst_s_tready", 64'(s_tready), 64'h0);

    // All four sources request 4-beat packets at once
    for (int i = 0; i < 4; i++) begin
      blen[i]  = 4;
      bleft[i] = 1;
    end
    drive_srcs();
    run_until(4, 100, "s1_pkt_count");
    check("s1_ngrants", 64'(gnt_log.size()), 64'd4);
    check("s1_grant0", 64'(get_gnt(0)), 64'h1);
    check("s1_grant1", 64'(get_gnt(1)), 64'h2);
    check("s1_grant2", 64'(get_gnt(2)), 64'h4);
    check("s1_grant3", 64'(get_gnt(3)), 64'h8);
    check("s1_nbeats", 64'(cap_q.size()), 64'd16);
    for (int k = 0; k < 16; k++) begin
      check("s1_beat", (k < cap_q.size()) ? cap_q[k] : 64'hdead, mkdata(k / 4, 0, k % 4));
    end
    check("s1_idle_grant", 64'(grant), 64'h0);

    // Single requester: three 2-beat packets from source 2
    do_reset();
    blen[2]  = 2;
    bleft[2] = 3;
    drive_srcs();
    run_until(3, 50, "s2_pkt_count");
    check("s2_ngrants", 64'(gnt_log.size()), 64'd3);
    for (int k = 0; k < 3; k++) check("s2_grant", 64'(get_gnt(k)), 64'h4);
    check("s2_idle_gaps", 64'(gap_cnt), 64'd3);
    check("s2_nbeats", 64'(cap_q.size()), 64'd6);

    // Almost-full blocks new grants only
    do_reset();
    alm_full = 1'b1;
    blen[0]  = 4;
    bleft[0] = 1;
    drive_srcs();
    repeat (5) tick();
    check("s3_blocked_grant", 64'(grant), 64'h0);
    check("s3_blocked_beats", 64'(cap_q.size()), 64'd0);
    alm_full = 1'b0;
    tick();
    check("s3_grant_after_release", 64'(grant), 64'h1);
    tick();
    alm_full = 1'b1;
    run_until(1, 50, "s3_pkt_count");
    check("s3_nbeats", 64'(cap_q.size()), 64'd4);
    blen[1]  = 2;
    bleft[1] = 1;
    drive_srcs();
    repeat (3) tick();
    check("s3_reblocked_grant", 64'(grant), 64'h0);
    alm_full = 1'b0;

    // 50% downstream backpressure on an 8-beat packet from source 1
    do_reset();
    toggle_rdy = 1'b1;
    blen[1]    = 8;
    bleft[1]   = 1;
    drive_srcs();
    for (int n = 0; n < 60 && pkt_count != 32'd1; n++) begin
      if (grant == 4'b0010) check("s4_tready_mirror", 64'(s_tready), 64'({2'b00, m_tready, 1'b0}));
      tick();
    end
    check("s4_pkt_count", 64'(pkt_count), 64'd1);
    check("s4_nbeats", 64'(cap_q.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check("s4_beat", (k < cap_q.size()) ? cap_q[k] : 64'hdead, mkdata(1, 0, k));
    end
    toggle_rdy = 1'b0;
    m_tready   = 1'b1;

    // Reset in the middle of a source 1 packet
    do_reset();
    blen[1]  = 8;
    bleft[1] = 1;
    drive_srcs();
    for (int n = 0; n < 20 && bbeat[1] != 2; n++) tick();
    check("s5_reached_beat2", 64'(bbeat[1]), 64'd2);
    rst = 1'b1;
    #1;
    check("s5_rst_m_tvalid", 64'(m_tvalid), 64'h0);
    check("s5_rst_s_tready", 64'(s_tready), 64'h0);
    tick();
    rst = 1'b0;
    check("s5_grant_cleared", 64'(grant), 64'h0);
    check("s5_pkt_cleared", 64'(pkt_count), 64'h0);
    clear_srcs();
    blen[0]  = 2;
    bleft[0] = 1;
    blen[1]  = 2;
    bleft[1] = 1;
    drive_srcs();
    gnt_log.delete();
    gnt_prev = grant;
    run_until(2, 50, "s5_pkt_count");
    check("s5_first_grant", 64'(get_gnt(0)), 64'h1);
    check("s5_second_grant", 64'(get_gnt(1)), 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aq_axis_arb.md
AQ_AXIS_ARB -- requirements
Module: aq_axis_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of AXI-Stream requesters (2..8).
REQ-002 SHALL have parameter FIFO_WIDTH, default 64, TDATA width per source.
REQ-003 SHALL have ports (one clock; reset is synchronous and active-high):
- ACLK in 1: sole clock.
- RST in 1: synchronous active-high reset.
- S_AXIS_TVALID in NUM_SRC: per-source valid.
- S_AXIS_TREADY out NUM_SRC: per-source ready.
- S_AXIS_TLAST in NUM_SRC: per-source last beat.
- S_AXIS_TDATA in NUM_SRC*FIFO_WIDTH: source i occupies bits [i*W +: W].
- M_AXIS_TVALID out 1: to aq_axis_fifo write side.
- M_AXIS_TREADY in 1: from aq_axis_fifo.
- M_AXIS_TLAST out 1: forwarded last.
- M_AXIS_TDATA out FIFO_WIDTH: forwarded data.
- FIFO_WR_ALM_FULL in 1: fifo almost-full, gates new grants.
- GRANT out NUM_SRC: one-hot current owner, 0 when idle.
- PKT_COUNT out 32: completed packets since reset.

Function
REQ-004 SHALL implement states IDLE and XFER.
REQ-005 In IDLE with any S_AXIS_TVALID high and FIFO_WR_ALM_FULL low, SHALL select one source round-robin, register GRANT, go to XFER next cycle (1-cycle grant latency).
REQ-006 Round-robin SHALL start search at index (last granted + 1) mod NUM_SRC; after reset the pointer SHALL make source 0 highest priority.
REQ-007 In IDLE, all S_AXIS_TREADY and M_AXIS_TVALID SHALL be 0.
REQ-008 In XFER, M_AXIS_TVALID/TDATA/TLAST SHALL combinationally equal the granted source's; granted S_AXIS_TREADY SHALL equal M_AXIS_TREADY; others 0.
REQ-009 A beat SHALL transfer when M_AXIS_TVALID and M_AXIS_TREADY are both high; zero bubbles between beats of one packet.
REQ-010 On transfer with TLAST=1: SHALL return to IDLE, clear GRANT, increment PKT_COUNT (wraps 2^32-1 -> 0), update pointer to granted index.
REQ-011 FIFO_WR_ALM_FULL SHALL block only new grants; packet in progress continues, backpressured solely by M_AXIS_TREADY.
REQ-012 Granted source dropping TVALID mid-packet SHALL hold ownership (no preemption, no timeout).
REQ-013 Single requester SHALL be re-granted after its packet with one IDLE cycle gap.

Reset
REQ-014 RST high at ACLK edge SHALL force IDLE, GRANT=0, PKT_COUNT=0, pointer to source 0, regardless of state; partial packet is abandoned (no TLAST synthesized).
REQ-015 During RST, all TREADY and M_AXIS_TVALID SHALL be 0.

Configuration
REQ-016 With AQ_AXIS_ARB_TID_EN defined, SHALL add output M_AXIS_TID (clog2(NUM_SRC) bits) = granted source index, 0 in IDLE; without it the port and logic SHALL not exist.

Structure
REQ-017 Package aq_axis_pkg SHALL hold state encoding (IDLE/XFER) and TID width function; round-robin selection SHALL be sub-module aq_rr_arbiter (request vector, pointer in, one-hot grant out, combinational).

Verification
REQ-018 Bench SHALL cover:
- Sources 0..3 each 4-beat packets valid at once, TREADY=1 -> grant order 0,1,2,3, PKT_COUNT=4, 16 beats, data unmixed.
- Only source 2 sends 3 packets -> GRANT=0b0100 each, one idle cycle between packets, PKT_COUNT=3.
- ALM_FULL=1 before request -> GRANT stays 0; deassert -> grant next cycle; ALM_FULL rising mid-packet -> packet completes.
- M_AXIS_TREADY toggled 50% on 8-beat packet -> all 8 beats in order, source TREADY mirrors.
- RST pulsed at beat 2 of source 1 packet -> GRANT=0, PKT_COUNT=0, next grant to source 0 when 0 and 1 both request.
- With AQ_AXIS_ARB_TID_EN: M_AXIS_TID = 3 during source 3 packet, 0 idle.
